one_hot: RTL and testbench
==========================

Name: one_hot

Overview:
- Registered binary-to-one-hot decoder: converts an IN_W-bit index into a 2**IN_W-bit vector with exactly the addressed bit set.
- Default configuration is 6 bits in, 64 bits out.
- Sits between control logic that produces a select index and any per-lane enable/select fabric such as mux selects, write-enable banks or arbiter masks.
- One clock domain; output is registered with 1-cycle latency.

Parameters:
- IN_W, 6, index width in bits; legal range 1..8.
- OUT_W, 2**IN_W (64), output vector width. Derived from IN_W and must not be overridden independently.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of the output vector
- in_valid  input  1  qualifies `in` for the current cycle
- in  input  IN_W  binary index to decode
- out  output  OUT_W  registered one-hot vector; out[k]=1 iff the last accepted index was k
- out_valid  output  1  high for one cycle after each accepted index

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - out = 0 (all bits clear), out_valid = 0.
  - Takes effect immediately, including mid-stream.
  - First edge after rst_n rises behaves as a normal cycle.
- Priority at each rising clk edge: reset > clr > in_valid > hold.
- clr=1:
  - out <= 0, out_valid <= 0.
  - in_valid is ignored in that cycle, even if asserted simultaneously.
- in_valid=1 (clr=0):
  - out <= vector with bit `in` set and all other bits 0; out_valid <= 1.
  - Latency: exactly 1 cycle from the sampling edge to visible out.
- in_valid=0 (clr=0):
  - out holds its previous value; out_valid <= 0.
- Back-to-back in_valid: every cycle is accepted. There is no backpressure and no ready signal.
- Decoding must be exhaustive over all 2**IN_W codes:
  - in=0 sets out[0]; in=OUT_W-1 (63) sets out[63].
  - No wrap-around and no out-of-range code exists.
- Invariant: popcount(out) is 0 only after reset or clr, and exactly 1 after any accepted index.
- `in` is don't-care when in_valid=0. X on `in` while in_valid=0 must not corrupt out.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ONE_HOT_CHECK_EN.
- When defined, the block adds:
  - Output port `onehot_err` (1 bit, registered). It is asserted in the cycle after `out` holds a value whose popcount is neither 0 nor 1, and it is sticky until reset or clr.
  - Output port `idx` (IN_W bits, registered). It re-encodes `out` back to binary, is valid whenever out_valid=1, and is 0 when out=0.
  - Reset values: onehot_err=0, idx=0.
- When not defined, neither port exists and the datapath is identical.
- In fault-free operation onehot_err must never assert.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in=5 and clocks running -> out=0, out_valid=0 throughout. Deassert rst_n -> the next accepted edge gives out=64'h20.
- Exhaustive sweep: in_valid=1, in=0..63 on consecutive cycles -> one cycle later out == (1<<in) each cycle and out_valid=1 continuously. Check in=0 gives 64'h1 and in=63 gives 64'h8000_0000_0000_0000.
- Hold: accept in=17, then in_valid=0 for 5 cycles with `in` toggling randomly -> out stays 64'h2_0000 and out_valid drops to 0 after the first edge.
- Clear vs valid collision: clr=1 and in_valid=1 with in=40 in the same cycle -> out=0, out_valid=0. The next cycle with in_valid=1, in=40 -> out=1<<40.
- Async reset mid-stream: assert rst_n=0 between clock edges while out=1<<63 -> out goes to 0 immediately, without waiting for a clk edge.
- With ONE_HOT_CHECK_EN: sweep 0..63 -> idx equals the accepted index and onehot_err stays 0. After clr -> idx=0 and out=0.

Source files
------------

// File: rtl/one_hot.sv
// Registered binary-to-one-hot decoder with 1-cycle latency and synchronous clear.
// Optional ONE_HOT_CHECK_EN adds a sticky popcount error flag and a re-encoded index output.
module one_hot #(
  parameter int IN_W = 6,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
`ifdef ONE_HOT_CHECK_EN
  ,
  output logic             onehot_err,
  output logic [IN_W-1:0]  idx
`endif
);

  logic [OUT_W-1:0] dec_next;
  logic [OUT_W-1:0] out_reg;
  logic [OUT_W-1:0] out_next;
  logic             valid_reg;
  logic             valid_next;

  // One comparator per lane; every code 0..OUT_W-1 maps to exactly one lane.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign dec_next[gi] = (in == IN_W'(gi));
    end
  endgenerate

  always_comb begin
    out_next   = out_reg;
    valid_next = 1'b0;
    if (clr) begin
      out_next = '0;
    end else if (in_valid) begin
      out_next   = dec_next;
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      out_reg   <= out_next;
      valid_reg <= valid_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = valid_reg;

`ifdef ONE_HOT_CHECK_EN
  logic            err_reg;
  logic            err_next;
  logic            multi_hot;
  logic            seen;
  logic [IN_W-1:0] idx_reg;
  logic [IN_W-1:0] idx_next;
  logic [IN_W-1:0] enc_next;

  // Popcount > 1 detector on the registered vector.
  always_comb begin
    seen      = 1'b0;
    multi_hot = 1'b0;
    for (int k = 0; k < OUT_W; k++) begin
      if (out_reg[k]) begin
        multi_hot = multi_hot | seen;
        seen      = 1'b1;
      end
    end
  end

  // OR-encoder; exact for a one-hot (or all-zero) vector.
  always_comb begin
    enc_next = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (out_next[k]) enc_next = enc_next | IN_W'(k);
    end
  end

  always_comb begin
    err_next = err_reg | multi_hot;
    idx_next = enc_next;
    if (clr) begin
      err_next = 1'b0;
      idx_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
      idx_reg <= '0;
    end else begin
      err_reg <= err_next;
      idx_reg <= idx_next;
    end
  end

  assign onehot_err = err_reg;
  assign idx        = idx_reg;
`endif

endmodule

// File: tb/tb_one_hot.sv
// Self-checking bench for one_hot: directed vector table plus reset, sweep, hold,
// clear-collision and async-reset sequences. Define ONE_HOT_CHECK_EN to also check idx/onehot_err.
module tb_one_hot;
  localparam int IN_W  = 6;
  localparam int OUT_W = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in = '0;
  logic [OUT_W-1:0] out;
  logic             out_valid;
`ifdef ONE_HOT_CHECK_EN
  logic             onehot_err;
  logic [IN_W-1:0]  idx;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             clr;
    logic             vld;
    logic [IN_W-1:0]  in;
    logic [OUT_W-1:0] exp_out;
    logic             exp_valid;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  one_hot #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in        (in),
    .out       (out),
    .out_valid (out_valid)
`ifdef ONE_HOT_CHECK_EN
    ,
    .onehot_err(onehot_err),
    .idx       (idx)
`endif
  );

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic [IN_W-1:0] i);
    clr      = c;
    in_valid = v;
    in       = i;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 6'd0,  64'h1,            1'b1};
    vecs[1]  = '{1'b0, 1'b1, 6'd63, 64'h1 << 63,      1'b1};
    vecs[2]  = '{1'b0, 1'b0, 6'd9,  64'h1 << 63,      1'b0};
    vecs[3]  = '{1'b1, 1'b0, 6'd9,  64'h0,            1'b0};
    vecs[4]  = '{1'b0, 1'b0, 6'd12, 64'h0,            1'b0};
    vecs[5]  = '{1'b0, 1'b1, 6'd31, 64'h8000_0000,    1'b1};
    vecs[6]  = '{1'b0, 1'b1, 6'd32, 64'h1_0000_0000,  1'b1};
    vecs[7]  = '{1'b1, 1'b1, 6'd7,  64'h0,            1'b0};
    vecs[8]  = '{1'b0, 1'b1, 6'd7,  64'h80,           1'b1};
    vecs[9]  = '{1'b0, 1'b1, 6'd7,  64'h80,           1'b1};
    vecs[10] = '{1'b0, 1'b0, 6'd2,  64'h80,           1'b0};
    vecs[11] = '{1'b0, 1'b1, 6'd1,  64'h2,            1'b1};

    // Reset held with a valid input and running clock
    drive(1'b0, 1'b1, 6'd5);
    for (int c = 0; c < 3; c++) begin
      step();
      check("reset_out", out, 64'h0);
      check("reset_valid", {63'b0, out_valid}, 64'h0);
`ifdef ONE_HOT_CHECK_EN
      check("reset_idx", {58'b0, idx}, 64'h0);
      check("reset_err", {63'b0, onehot_err}, 64'h0);
`endif
    end
    rst_n = 1'b1;
    step();
    check("post_reset_out", out, 64'h20);
    check("post_reset_valid", {63'b0, out_valid}, 64'h1);
    $display("reset: out=%h out_valid=%0b", out, out_valid);

    // Directed table
    for (int t = 0; t < 12; t++) begin
      drive(vecs[t].clr, vecs[t].vld, vecs[t].in);
      step();
      check($sformatf("vec%0d_out", t), out, vecs[t].exp_out);
      check($sformatf("vec%0d_valid", t), {63'b0, out_valid}, {63'b0, vecs[t].exp_valid});
      $display("vec %0d: clr=%0b vld=%0b in=%0d out=%h out_valid=%0b",
               t, vecs[t].clr, vecs[t].vld, vecs[t].in, out, out_valid);
    end

    // Exhaustive back-to-back sweep
    for (int i = 0; i < OUT_W; i++) begin
      drive(1'b0, 1'b1, IN_W'(i));
      step();
      check($sformatf("sweep%0d_out", i), out, 64'h1 << i);
      check($sformatf("sweep%0d_valid", i), {63'b0, out_valid}, 64'h1);
`ifdef ONE_HOT_CHECK_EN
      check($sformatf("sweep%0d_idx", i), {58'b0, idx}, 64'(i));
      check($sformatf("sweep%0d_err", i), {63'b0, onehot_err}, 64'h0);
`endif
      $display("sweep in=%0d out=%h out_valid=%0b", i, out, out_valid);
    end

    // Hold with toggling / unknown index
    drive(1'b0, 1'b1, 6'd17);
    step();
    check("hold_accept", out, 64'h2_0000);
    for (int h = 0; h < 5; h++) begin
      drive(1'b0, 1'b0, IN_W'($urandom_range(0, 63)));
      if (h == 2) in = 'x;
      step();
      check($sformatf("hold%0d_out", h), out, 64'h2_0000);
      check($sformatf("hold%0d_valid", h), {63'b0, out_valid}, 64'h0);
      $display("hold %0d: out=%h out_valid=%0b", h, out, out_valid);
    end

    // Clear collides with valid
    drive(1'b1, 1'b1, 6'd40);
    step();
    check("collide_out", out, 64'h0);
    check("collide_valid", {63'b0, out_valid}, 64'h0);
`ifdef ONE_HOT_CHECK_EN
    check("collide_idx", {58'b0, idx}, 64'h0);
    check("collide_err", {63'b0, onehot_err}, 64'h0);
`endif
    drive(1'b0, 1'b1, 6'd40);
    step();
    check("after_collide_out", out, 64'h1 << 40);
    check("after_collide_valid", {63'b0, out_valid}, 64'h1);
    $display("collide: out=%h out_valid=%0b", out, out_valid);

    // Asynchronous reset between edges
    drive(1'b0, 1'b1, 6'd63);
    step();
    check("pre_async_out", out, 64'h1 << 63);
    #2 rst_n = 1'b0;
    #1;
    check("async_out", out, 64'h0);
    check("async_valid", {63'b0, out_valid}, 64'h0);
    $display("async reset: out=%h out_valid=%0b", out, out_valid);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 6'd3);
    step();
    check("post_async_out", out, 64'h8);
    check("post_async_valid", {63'b0, out_valid}, 64'h1);
    $display("post async: out=%h out_valid=%0b", out, out_valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
